// File: rtl/hazard_stall_controller.sv
// -----------------------------------------------------------------------------
// hazard_stall_controller
//
// Hazard and sequencing controller for the 5-stage MIPS pipeline. It decides
// when fetch/decode must hold, when the decode and execute registers must be
// cleared, and which forwarding paths feed the decode comparator and the ALU.
// It also tracks the multi-cycle mult/div unit with a small IDLE/BUSY FSM.
//
// Build option:
//   HAZARD_FORWARDING_EN  defined   -> M/W forwarding enabled, no RAW stall
//                         undefined -> forwarding selects tied to 0, every
//                                      RAW on an E or M producer stalls
//                                      decode (W is covered by the
//                                      write-first register file)
//
// Ports:
//   CLK, RST                 clock, asynchronous active-low reset
//   RsD, RtD                 decode source registers
//   RsE, RtE                 execute source registers
//   WriteRegE/M/W            destination register in E/M/W
//   RegWriteE/M/W            destination write enable in E/M/W
//   MemtoRegE/M              load in E/M
//   BranchD, JumpD, PCSrcD   branch in D, jump in D, branch taken
//   MdUseD                   decode instruction needs the mult/div unit
//   MdStartE, MdDivE         mult/div issue in E, 1 = div / 0 = mult
//   StallF, StallD, FlushE   pipeline hold / bubble
//   FlushD                   clear F->D register on redirect
//   ForwardAD, ForwardBD     decode comparator forward from M
//   ForwardAE, ForwardBE     ALU operand select: 00 RF, 10 M, 01 W
//   MdBusy                   mult/div unit busy
//   StallCount               saturating count of cycles with StallD = 1
// -----------------------------------------------------------------------------
module hazard_stall_controller #(
  parameter int REG_ADDR_W = 5,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6,
  parameter int PERF_W     = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [REG_ADDR_W-1:0] RsD,
  input  logic [REG_ADDR_W-1:0] RtD,
  input  logic [REG_ADDR_W-1:0] RsE,
  input  logic [REG_ADDR_W-1:0] RtE,
  input  logic [REG_ADDR_W-1:0] WriteRegE,
  input  logic [REG_ADDR_W-1:0] WriteRegM,
  input  logic [REG_ADDR_W-1:0] WriteRegW,
  input  logic                  RegWriteE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  MemtoRegE,
  input  logic                  MemtoRegM,
  input  logic                  BranchD,
  input  logic                  JumpD,
  input  logic                  PCSrcD,
  input  logic                  MdUseD,
  input  logic                  MdStartE,
  input  logic                  MdDivE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  ForwardAD,
  output logic                  ForwardBD,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  MdBusy,
  output logic [PERF_W-1:0]     StallCount
);

`ifdef HAZARD_FORWARDING_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  md_state_t             state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [PERF_W-1:0]     stall_count_r;

  logic                  lwstall_s;
  logic                  brstall_s;
  logic                  mdstall_s;
  logic                  rawstall_s;
  logic                  stall_s;
  logic                  hit_e_s;
  logic                  hit_m_s;
  logic                  hit_load_m_s;
  logic [1:0]            fwd_ae_s;
  logic [1:0]            fwd_be_s;

  // A producer matches a consumer only if it writes and the register is not R0.
  function automatic logic reg_hit(
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] dst,
    input logic                  we
  );
    return we && (src != {REG_ADDR_W{1'b0}}) && (src == dst);
  endfunction

  // Execute-stage operand select: the younger M result beats the W result.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] src
  );
    logic [1:0] sel;
    if (reg_hit(src, WriteRegM, RegWriteM)) begin
      sel = 2'b10;
    end else if (reg_hit(src, WriteRegW, RegWriteW)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Hazard detection: load-use, branch operand not ready, busy mult/div, RAW.
  always_comb begin
    hit_e_s      = reg_hit(RsD, WriteRegE, RegWriteE) | reg_hit(RtD, WriteRegE, RegWriteE);
    hit_m_s      = reg_hit(RsD, WriteRegM, RegWriteM) | reg_hit(RtD, WriteRegM, RegWriteM);
    hit_load_m_s = reg_hit(RsD, WriteRegM, MemtoRegM) | reg_hit(RtD, WriteRegM, MemtoRegM);
    lwstall_s    = MemtoRegE & hit_e_s;
    brstall_s    = BranchD & (hit_e_s | hit_load_m_s);
    mdstall_s    = MdUseD & (state_r == BUSY);
    // Without forwarding every in-flight E/M producer must drain first.
    rawstall_s   = ~FWD_EN & (hit_e_s | hit_m_s);
    stall_s      = lwstall_s | brstall_s | mdstall_s | rawstall_s;
  end

  // Forwarding selects, forced to the register-file path when disabled.
  always_comb begin
    fwd_ae_s = fwd_sel(RsE);
    fwd_be_s = fwd_sel(RtE);
    if (FWD_EN) begin
      ForwardAE = fwd_ae_s;
      ForwardBE = fwd_be_s;
      ForwardAD = reg_hit(RsD, WriteRegM, RegWriteM);
      ForwardBD = reg_hit(RtD, WriteRegM, RegWriteM);
    end else begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      ForwardAD = 1'b0;
      ForwardBD = 1'b0;
    end
  end

  // Stall/flush drive; a held decode stage must never be cleared by a redirect.
  always_comb begin
    StallF = stall_s;
    StallD = stall_s;
    FlushE = stall_s;
    FlushD = (PCSrcD | JumpD) & ~stall_s;
  end

  // Mult/div busy tracker: load the op length minus one, count down to zero.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (MdStartE) begin
            state_r <= BUSY;
            cnt_r   <= MdDivE ? DIV_LOAD : MUL_LOAD;
          end else begin
            state_r <= IDLE;
            cnt_r   <= cnt_r;
          end
        end
        BUSY: begin
          // An issue while busy cannot happen (decode is stalled), so ignore it.
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r <= IDLE;
            cnt_r   <= cnt_r;
          end else begin
            state_r <= BUSY;
            cnt_r   <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Saturating stall-cycle performance counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_count_r <= {PERF_W{1'b0}};
    end else if (stall_s && (stall_count_r != {PERF_W{1'b1}})) begin
      stall_count_r <= stall_count_r + PERF_W'(1);
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign MdBusy     = (state_r == BUSY);
  assign StallCount = stall_count_r;

endmodule
